// File: rtl/vga_timing_compositor_if.sv
// Display-path bundle: run enable and layer colours in, timing, coordinates and composited pixel out.
// The slave side is the compositor; the master side is the game logic / pixel sources.
interface vga_timing_compositor_if #(
    parameter int CW = 12
);
    logic          en;
    logic [CW-1:0] layer_a;
    logic [CW-1:0] layer_b;
    logic [9:0]    x_pos;
    logic [9:0]    y_pos;
    logic          pix_tick;
    logic          frame_start;
    logic          line_start;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] color_out;

    modport master (
        output en, layer_a, layer_b,
        input  x_pos, y_pos, pix_tick, frame_start, line_start, hsync, vsync, de, color_out
    );

    modport slave (
        input  en, layer_a, layer_b,
        output x_pos, y_pos, pix_tick, frame_start, line_start, hsync, vsync, de, color_out
    );
endinterface

// File: rtl/vga_timing_compositor.sv
// VGA timing generator and two-layer compositor; sync/DE/colour appear PIPE_DLY pixel ticks after the counters.
// No backpressure: the pixel clock free-runs while en is high, and pixel sources must keep up.
module vga_timing_compositor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 2,
    parameter int CW       = 12,
    parameter int MIX_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    vga_timing_compositor_if.slave  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int F       = CW / 3;
    localparam int SW      = 3 * PIPE_DLY;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [9:0]    hcnt;
    logic [9:0]    vcnt;
    logic          tick;
    logic          raw_de, raw_hs, raw_vs;
    logic [SW-1:0] sr, sr_next;
    logic          de_next;
    logic [CW-1:0] mix;
    logic [F:0]    sum;
    logic [CW-1:0] color_q;

    // Gating with rst keeps the strobe low during reset even when CLK_DIV is 1.
    assign tick = bus.en && !rst && (div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div  <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else if (!bus.en) begin
            div  <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

    assign raw_de = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign raw_hs = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign raw_vs = (vcnt >= VS_BEG) && (vcnt < VS_END);

    // Groups of {hs, vs, de}; the top group is the output stage, so the total delay is PIPE_DLY ticks.
    always_comb begin
        sr_next      = sr;
        sr_next[2:0] = {raw_hs, raw_vs, raw_de};
        for (int i = 1; i < PIPE_DLY; i++) begin
            sr_next[3*i +: 3] = sr[3*(i-1) +: 3];
        end
    end

    assign de_next = sr_next[SW-3];

    always_comb begin
        mix = '0;
        sum = '0;
        case (MIX_MODE)
            0: mix = bus.layer_a | bus.layer_b;
            1: mix = (bus.layer_a != '0) ? bus.layer_a : bus.layer_b;
            default: begin
                for (int f = 0; f < 3; f++) begin
                    sum = {1'b0, bus.layer_a[f*F +: F]} + {1'b0, bus.layer_b[f*F +: F]};
                    mix[f*F +: F] = sum[F] ? {F{1'b1}} : sum[F-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            color_q <= '0;
        end else if (!bus.en) begin
            sr      <= '0;
            color_q <= '0;
        end else if (tick) begin
            sr      <= sr_next;
            color_q <= de_next ? mix : '0;
        end
    end

    assign bus.x_pos       = hcnt;
    assign bus.y_pos       = vcnt;
    assign bus.pix_tick    = tick;
    assign bus.frame_start = tick && (hcnt == '0) && (vcnt == '0);
    assign bus.line_start  = tick && (hcnt == '0);
    assign bus.hsync       = (bus.en && sr[SW-1]) ? SYNC_POL : ~SYNC_POL;
    assign bus.vsync       = (bus.en && sr[SW-2]) ? SYNC_POL : ~SYNC_POL;
    assign bus.de          = bus.en && sr[SW-3];
    assign bus.color_out   = bus.en ? color_q : '0;
endmodule

// File: tb/tb_vga_timing_compositor.sv
// Bench for vga_timing_compositor on a shrunken raster; three instances share timing and differ only in mix mode.
// Expected outputs come from the pixel index implied by the number of clk edges since reset release / en rise.
module tb_vga_timing_compositor;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int CD = 4,  PD = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int NPIX = HT * VT;

    typedef struct packed {
        logic        tick;
        logic        fs;
        logic        ls;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] c0;
        logic [11:0] c1;
        logic [11:0] c2;
    } snap_t;

    logic        clk, rst, en;
    logic [11:0] la, lb;
    int          total = 0;
    int          bad = 0;
    int          e = 0;
    logic [11:0] ta  [NPIX];
    logic [11:0] tbl [NPIX];

    vga_timing_compositor_if #(.CW(12)) v0 ();
    vga_timing_compositor_if #(.CW(12)) v1 ();
    vga_timing_compositor_if #(.CW(12)) v2 ();

    assign v0.en = en;  assign v0.layer_a = la;  assign v0.layer_b = lb;
    assign v1.en = en;  assign v1.layer_a = la;  assign v1.layer_b = lb;
    assign v2.en = en;  assign v2.layer_a = la;  assign v2.layer_b = lb;

    vga_timing_compositor #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
        .V_SYNC(VS), .V_BP(VB), .CLK_DIV(CD), .SYNC_POL(1'b0), .PIPE_DLY(PD), .CW(12), .MIX_MODE(0))
        dut0 (.clk(clk), .rst(rst), .bus(v0.slave));
    vga_timing_compositor #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
        .V_SYNC(VS), .V_BP(VB), .CLK_DIV(CD), .SYNC_POL(1'b0), .PIPE_DLY(PD), .CW(12), .MIX_MODE(1))
        dut1 (.clk(clk), .rst(rst), .bus(v1.slave));
    vga_timing_compositor #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
        .V_SYNC(VS), .V_BP(VB), .CLK_DIV(CD), .SYNC_POL(1'b0), .PIPE_DLY(PD), .CW(12), .MIX_MODE(2))
        dut2 (.clk(clk), .rst(rst), .bus(v2.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pixel source with one tick of latency: looks up the colour for the coordinate shown on a tick.
    initial begin : source
        int idx;
        forever begin
            @(negedge clk);
            if (v0.pix_tick === 1'b1) begin
                idx = int'(v0.y_pos) * HT + int'(v0.x_pos);
                if (idx >= NPIX) idx = 0;
                @(posedge clk);
                #1;
                la = ta[idx];
                lb = tbl[idx];
            end
        end
    end

    function automatic logic [11:0] mixref(int mode, logic [11:0] a, logic [11:0] b);
        int s;
        logic [11:0] r;
        if (mode == 0) return a | b;
        if (mode == 1) return (a != 12'h000) ? a : b;
        r = 12'h000;
        for (int ch = 0; ch < 3; ch++) begin
            s = int'((a >> (4*ch)) & 12'hF) + int'((b >> (4*ch)) & 12'hF);
            if (s > 15) s = 15;
            r = r | (12'(s) << (4*ch));
        end
        return r;
    endfunction

    // Expected outputs after ecnt clk edges of running: counters show pixel t, outputs show pixel t-PD.
    function automatic snap_t model(int ecnt);
        snap_t s;
        int t, p, q, px, py;
        s = '0;
        s.hs = 1'b1;
        s.vs = 1'b1;
        t = ecnt / CD;
        p = t % NPIX;
        s.tick = ((ecnt % CD) == CD - 1);
        s.x = 10'(p % HT);
        s.y = 10'(p / HT);
        s.fs = s.tick && (p == 0);
        s.ls = s.tick && ((p % HT) == 0);
        if (t >= PD) begin
            q  = (t - PD) % NPIX;
            px = q % HT;
            py = q / HT;
            s.de = (px < HA) && (py < VA);
            s.hs = !((px >= HA + HF) && (px < HA + HF + HS));
            s.vs = !((py >= VA + VF) && (py < VA + VF + VS));
            if (s.de) begin
                s.c0 = mixref(0, ta[q], tbl[q]);
                s.c1 = mixref(1, ta[q], tbl[q]);
                s.c2 = mixref(2, ta[q], tbl[q]);
            end
        end
        return s;
    endfunction

    function automatic snap_t observe();
        snap_t o;
        o.tick = v0.pix_tick;  o.fs = v0.frame_start;  o.ls = v0.line_start;
        o.x = v0.x_pos;        o.y = v0.y_pos;
        o.hs = v0.hsync;       o.vs = v0.vsync;        o.de = v0.de;
        o.c0 = v0.color_out;   o.c1 = v1.color_out;    o.c2 = v2.color_out;
        return o;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) begin
            ta[i]  = ($urandom_range(3) == 0) ? 12'h000 : 12'($urandom);
            tbl[i] = 12'($urandom);
        end
    endtask

    task automatic fill_const(logic [11:0] a, logic [11:0] b);
        for (int i = 0; i < NPIX; i++) begin
            ta[i]  = a;
            tbl[i] = b;
        end
    endtask

    task automatic restart();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        en = 1'b1;
        e = 0;
    endtask

    task automatic test_reset();
        snap_t o, x;
        #1;
        o = observe(); x = model(0); total++;
        if (o !== x) begin bad++; $display("FAIL reset_async got=%h exp=%h", o, x); end
        repeat (2) @(negedge clk);
        o = observe(); total++;
        if (o !== x) begin bad++; $display("FAIL reset_held got=%h exp=%h", o, x); end
    endtask

    task automatic test_frame_timing();
        snap_t o, x;
        logic phs, pvs;
        int hf0 = -1, hf1 = -1, hr0 = -1, vf0 = -1, vf1 = -1, vr0 = -1, f0 = -1, f1 = -1;
        fill_random();
        @(negedge clk);
        #2 rst = 1'b0;
        e = 0;
        phs = 1'b1;
        pvs = 1'b1;
        repeat (2 * NPIX * CD + 300) begin
            @(posedge clk); e++; @(negedge clk);
            o = observe(); x = model(e); total++;
            if (o !== x) begin bad++; $display("FAIL frame_model e=%0d got=%h exp=%h", e, o, x); end
            if (phs && !o.hs) begin if (hf0 < 0) hf0 = e; else if (hf1 < 0) hf1 = e; end
            if (!phs && o.hs && hf0 >= 0 && hr0 < 0) hr0 = e;
            if (pvs && !o.vs) begin if (vf0 < 0) vf0 = e; else if (vf1 < 0) vf1 = e; end
            if (!pvs && o.vs && vf0 >= 0 && vr0 < 0) vr0 = e;
            if (o.fs) begin if (f0 < 0) f0 = e; else if (f1 < 0) f1 = e; end
            phs = o.hs;
            pvs = o.vs;
        end
        total++;
        if (hf0 < 0 || hf1 - hf0 != HT * CD) begin bad++; $display("FAIL hsync_period got=%0d exp=%0d", hf1 - hf0, HT * CD); end
        total++;
        if (hf0 < 0 || hr0 - hf0 != HS * CD) begin bad++; $display("FAIL hsync_low got=%0d exp=%0d", hr0 - hf0, HS * CD); end
        total++;
        if (vf0 < 0 || vf1 - vf0 != NPIX * CD) begin bad++; $display("FAIL vsync_period got=%0d exp=%0d", vf1 - vf0, NPIX * CD); end
        total++;
        if (vf0 < 0 || vr0 - vf0 != VS * HT * CD) begin bad++; $display("FAIL vsync_low got=%0d exp=%0d", vr0 - vf0, VS * HT * CD); end
        total++;
        if (f0 < 0 || f1 - f0 != NPIX * CD) begin bad++; $display("FAIL frame_start_spacing got=%0d exp=%0d", f1 - f0, NPIX * CD); end
    endtask

    task automatic test_overlay();
        snap_t o, x;
        int detick = 0, hits = 0, hit_at = -1, x18 = -1, hs_low = -1;
        for (int i = 0; i < NPIX; i++) begin
            ta[i]  = ((i % HT) == 10) ? 12'hF00 : 12'h000;
            tbl[i] = 12'h000;
        end
        restart();
        repeat (100) begin
            @(posedge clk); e++; @(negedge clk);
            o = observe(); x = model(e); total++;
            if (o !== x) begin bad++; $display("FAIL overlay_model e=%0d got=%h exp=%h", e, o, x); end
            if (o.tick && o.de) begin
                detick++;
                if (o.c0 == 12'hF00) begin hits++; hit_at = detick; end
            end
            if (x18 < 0 && o.x == 10'd18) x18 = e;
            if (hs_low < 0 && o.hs == 1'b0) hs_low = e;
        end
        total++;
        if (hits != 1 || hit_at != 11) begin bad++; $display("FAIL overlay_pixel hits=%0d at=%0d exp hits=1 at=11", hits, hit_at); end
        total++;
        if (x18 < 0 || hs_low - x18 != PD * CD) begin bad++; $display("FAIL hsync_delay got=%0d exp=%0d", hs_low - x18, PD * CD); end
    endtask

    task automatic test_mix_patterns();
        logic [11:0] av [4] = '{12'h0F0, 12'h000, 12'h800, 12'h8F1};
        logic [11:0] bv [4] = '{12'h00F, 12'h00F, 12'h900, 12'h9A3};
        logic [35:0] ev [4] = '{{12'h0FF, 12'h0F0, 12'h0FF}, {12'h00F, 12'h00F, 12'h00F},
                                {12'h900, 12'h800, 12'hF00}, {12'h9F3, 12'h8F1, 12'hFF4}};
        snap_t o, x;
        for (int k = 0; k < 4; k++) begin
            fill_const(av[k], bv[k]);
            restart();
            repeat (40) begin
                @(posedge clk); e++; @(negedge clk);
                o = observe(); x = model(e); total++;
                if (o !== x) begin bad++; $display("FAIL mix_model k=%0d e=%0d got=%h exp=%h", k, e, o, x); end
            end
            total++;
            if ({o.c0, o.c1, o.c2} !== ev[k]) begin
                bad++; $display("FAIL mix_const k=%0d got=%h exp=%h", k, {o.c0, o.c1, o.c2}, ev[k]);
            end
        end
    endtask

    task automatic test_random_mix();
        snap_t o, x;
        fill_random();
        restart();
        repeat (NPIX * CD + 20) begin
            @(posedge clk); e++; @(negedge clk);
            o = observe(); x = model(e); total++;
            if (o !== x) begin bad++; $display("FAIL random_mix e=%0d got=%h exp=%h", e, o, x); end
        end
    endtask

    task automatic test_en_low();
        snap_t o, x;
        logic found = 1'b0;
        fill_random();
        restart();
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk); e++; @(negedge clk);
            o = observe(); x = model(e); total++;
            if (o !== x) begin bad++; $display("FAIL en_pre e=%0d got=%h exp=%h", e, o, x); end
            if (e > 100 && o.hs == 1'b0) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL en_wait_hsync got=timeout exp=hsync low"); end
        en = 1'b0;
        #1;
        o = observe(); total++;
        if ({o.tick, o.hs, o.vs, o.de, o.c0, o.c1, o.c2} !== {4'b0110, 36'h0}) begin
            bad++; $display("FAIL en_low_immediate got=%h exp=%h", {o.tick, o.hs, o.vs, o.de, o.c0, o.c1, o.c2}, {4'b0110, 36'h0});
        end
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            o = observe(); x = model(0); total++;
            if (o !== x) begin bad++; $display("FAIL en_low got=%h exp=%h", o, x); end
        end
        en = 1'b1;
        e = 0;
        repeat (NPIX * CD + 50) begin
            @(posedge clk); e++; @(negedge clk);
            o = observe(); x = model(e); total++;
            if (o !== x) begin bad++; $display("FAIL en_resume e=%0d got=%h exp=%h", e, o, x); end
            if (e == 3) begin
                total++;
                if ({o.tick, o.fs, o.x, o.y} !== {2'b11, 20'h0}) begin
                    bad++; $display("FAIL en_first_tick got=%h exp=%h", {o.tick, o.fs, o.x, o.y}, {2'b11, 20'h0});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        snap_t o, x;
        logic found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk); e++; @(negedge clk);
            o = observe(); x = model(e); total++;
            if (o !== x) begin bad++; $display("FAIL rst_pre e=%0d got=%h exp=%h", e, o, x); end
            if (o.hs == 1'b0 && o.y != 10'd0) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL rst_wait_hsync got=timeout exp=hsync low"); end
        #2 rst = 1'b1;
        #1;
        o = observe(); x = model(0); total++;
        if (o !== x) begin bad++; $display("FAIL rst_mid_frame got=%h exp=%h", o, x); end
        repeat (3) begin
            @(negedge clk);
            o = observe(); total++;
            if (o !== x) begin bad++; $display("FAIL rst_hold got=%h exp=%h", o, x); end
        end
        #2 rst = 1'b0;
        e = 0;
        repeat (NPIX * CD + 100) begin
            @(posedge clk); e++; @(negedge clk);
            o = observe(); x = model(e); total++;
            if (o !== x) begin bad++; $display("FAIL rst_resume e=%0d got=%h exp=%h", e, o, x); end
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        la  = 12'h000;
        lb  = 12'h000;
        fill_const(12'h000, 12'h000);
        test_reset();
        test_frame_timing();
        test_overlay();
        test_mix_patterns();
        test_random_mix();
        test_en_low();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
